// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer and its external shifter:
// datapath widths, shifter control encodings and the sequencer FSM states.
package shift_sequencer_pkg;

  localparam int unsigned NBITS     = 32;
  localparam int unsigned S_CONTROL = 2;

  localparam logic [1:0] SC_PASS = 2'b00;
  localparam logic [1:0] SC_SRA1 = 2'b01;
  localparam logic [1:0] SC_SLL8 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Combinational shifter driven by the sequencer: SLL8, SRA1 or pass-through.
module shift_sequencer_shifter
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned NBITS     = shift_sequencer_pkg::NBITS,
  parameter int unsigned S_CONTROL = shift_sequencer_pkg::S_CONTROL
) (
  input  logic [NBITS-1:0]     c,
  input  logic [S_CONTROL-1:0] s_control,
  output logic [NBITS-1:0]     c_bus
);

  always_comb begin
    c_bus = c;
    if (s_control == S_CONTROL'(SC_SLL8)) begin
      c_bus = c << 8;
    end else if (s_control == S_CONTROL'(SC_SRA1)) begin
      c_bus = NBITS'($signed(c) >>> 1);
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Wrapper pairing the shift sequencer with its shifter into one complete unit.
module shift_unit
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned NBITS     = shift_sequencer_pkg::NBITS,
  parameter int unsigned S_CONTROL = shift_sequencer_pkg::S_CONTROL,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [CNT_W-1:0] count,
  input  logic [NBITS-1:0] data_in,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result
);

  logic [NBITS-1:0]     c;
  logic [NBITS-1:0]     c_bus;
  logic [S_CONTROL-1:0] s_control;

  shift_sequencer #(
    .NBITS    (NBITS),
    .S_CONTROL(S_CONTROL),
    .CNT_W    (CNT_W)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .count    (count),
    .data_in  (data_in),
    .abort    (abort),
    .c        (c),
    .s_control(s_control),
    .c_bus    (c_bus),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  shift_sequencer_shifter #(
    .NBITS    (NBITS),
    .S_CONTROL(S_CONTROL)
  ) u_shf (
    .c        (c),
    .s_control(s_control),
    .c_bus    (c_bus)
  );

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass shift sequencer: loads an operand, runs it through an external
// shifter `count` times and reports the result with a one-cycle done pulse.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned NBITS     = shift_sequencer_pkg::NBITS,
  parameter int unsigned S_CONTROL = shift_sequencer_pkg::S_CONTROL,
  parameter int unsigned CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op,
  input  logic [CNT_W-1:0]     count,
  input  logic [NBITS-1:0]     data_in,
  input  logic                 abort,
  output logic [NBITS-1:0]     c,
  output logic [S_CONTROL-1:0] s_control,
  input  logic [NBITS-1:0]     c_bus,
  output logic                 busy,
  output logic                 done,
  output logic [NBITS-1:0]     result
);

  state_e           state_q, state_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             op_q, op_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = data_in;
          rem_d   = count;
          op_d    = op;
          state_d = (count != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        // Abort leaves acc at its partial value; the pass in flight is dropped.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = c_bus;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    s_control = S_CONTROL'(SC_PASS);
    if (state_q == ST_SHIFT) begin
      s_control = op_q ? S_CONTROL'(SC_SRA1) : S_CONTROL'(SC_SLL8);
    end
  end

  assign c      = acc_q;
  assign result = acc_q;
  assign busy   = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, hand-written
// abort/reset sequences and random operations against an arithmetic model.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  localparam int unsigned NB = 32;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst_n, start, op, abort;
  logic [CW-1:0] count;
  logic [NB-1:0] data_in, c, c_bus, result;
  logic [1:0]    s_control;
  logic          busy, done;
  logic          u_busy, u_done;
  logic [NB-1:0] u_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.NBITS(NB), .S_CONTROL(2), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .count(count),
    .data_in(data_in), .abort(abort), .c(c), .s_control(s_control),
    .c_bus(c_bus), .busy(busy), .done(done), .result(result)
  );

  shift_sequencer_shifter #(.NBITS(NB), .S_CONTROL(2)) u_shf (
    .c(c), .s_control(s_control), .c_bus(c_bus)
  );

  shift_unit #(.NBITS(NB), .S_CONTROL(2), .CNT_W(CW)) u_unit (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .count(count),
    .data_in(data_in), .abort(abort), .busy(u_busy), .done(u_done),
    .result(u_result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: SLL8 is multiply by 256 modulo 2^32, SRA1 is floor division by 2
  // of the two's-complement value.
  function automatic logic [31:0] ref_shift(input logic o, input int n, input logic [31:0] x);
    longint v;
    if (!o) begin
      v = longint'(x);
      for (int i = 0; i < n; i++) v = (v * 256) % 64'sh1_0000_0000;
    end else begin
      v = x[31] ? longint'(x) - 64'sh1_0000_0000 : longint'(x);
      for (int i = 0; i < n; i++) v = (v < 0 && (v % 2) != 0) ? (v - 1) / 2 : v / 2;
    end
    return 32'(v);
  endfunction

  // Start an operation, then walk cycles 1..n+2 checking the handshake, control
  // code and result. restart_k re-asserts start (with junk) during that cycle.
  task automatic run_op(input logic o, input int n, input logic [31:0] d,
                        input logic [31:0] exp, input int restart_k,
                        input logic abort_with_start, input string tag);
    logic [1:0] code;
    code = (n == 0) ? 2'b00 : (o ? 2'b01 : 2'b10);
    @(negedge clk);
    start = 1'b1; op = o; count = CW'(n); data_in = d; abort = abort_with_start;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      abort = 1'b0;
      check({tag, ".busy"}, 64'(busy), 64'(k <= n + 1));
      check({tag, ".done"}, 64'(done), 64'(k == n + 1));
      check({tag, ".sctl"}, 64'(s_control), 64'((k <= n) ? code : 2'b00));
      if (k == n + 1) begin
        check({tag, ".result"}, 64'(result), 64'(exp));
        check({tag, ".unit_done"}, 64'(u_done), 64'd1);
        check({tag, ".unit_result"}, 64'(u_result), 64'(exp));
      end
      if (k == n + 2) check({tag, ".held"}, 64'(result), 64'(exp));
      start = (k == restart_k);
      if (start) begin
        op = ~o; count = ~CW'(n); data_in = ~d;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic        op;
    int          n;
    logic [31:0] d;
    logic [31:0] exp;
    int          restart;
    logic        abs;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1,  3, 32'h8000_0010, 32'hF000_0002, 0, 1'b0};
    vecs[1] = '{1'b0,  2, 32'h0000_12AB, 32'h12AB_0000, 0, 1'b0};
    vecs[2] = '{1'b0,  0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1'b0};
    vecs[3] = '{1'b0,  5, 32'h1234_5678, 32'h0000_0000, 2, 1'b0};
    vecs[4] = '{1'b1, 31, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0};
    vecs[5] = '{1'b1, 31, 32'h7FFF_FFFF, 32'h0000_0000, 0, 1'b0};
    vecs[6] = '{1'b0,  1, 32'h0000_00FF, 32'h0000_FF00, 2, 1'b1};
    vecs[7] = '{1'b1,  1, 32'h0000_0003, 32'h0000_0001, 0, 1'b0};
    vecs[8] = '{1'b0,  3, 32'h0000_00AB, 32'hAB00_0000, 4, 1'b0};
    vecs[9] = '{1'b1,  0, 32'h8000_0001, 32'h8000_0001, 1, 1'b0};

    rst_n = 1'b0; start = 1'b1; op = 1'b1; abort = 1'b1;
    count = '1; data_in = '1;
    repeat (2) @(negedge clk);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.c", 64'(c), 64'd0);
    check("rst.sctl", 64'(s_control), 64'd0);
    start = 1'b0; abort = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("idle.busy", 64'(busy), 64'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].n, vecs[i].d, vecs[i].exp,
             vecs[i].restart, vecs[i].abs, $sformatf("vec%0d", i));
    end

    // Abort in cycle 2 of an SRA1 x4 run: only the cycle-1 pass lands in acc.
    @(negedge clk);
    start = 1'b1; op = 1'b1; count = CW'(4); data_in = 32'h8000_0100;
    @(negedge clk);
    start = 1'b0;
    check("abort.busy1", 64'(busy), 64'd1);
    @(negedge clk);
    check("abort.sctl2", 64'(s_control), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort.busy3", 64'(busy), 64'd0);
    check("abort.done3", 64'(done), 64'd0);
    check("abort.partial", 64'(result), 64'h0000_0000_C000_0080);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("abort.nodone", 64'(done | u_done), 64'd0);
    end
    run_op(1'b0, 2, 32'h0000_00C3, 32'h00C3_0000, 0, 1'b0, "post_abort");

    // Reset in the middle of a long run discards it without a done pulse.
    @(negedge clk);
    start = 1'b1; op = 1'b0; count = CW'(10); data_in = 32'h0000_0011;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    check("midrst.result", 64'(result), 64'd0);
    check("midrst.sctl", 64'(s_control), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("midrst.quiet", 64'({busy, done}), 64'd0);
    end

    for (int i = 0; i < 30; i++) begin
      logic        ro;
      int          rn;
      logic [31:0] rd;
      ro = 1'($urandom);
      rn = int'($urandom_range(0, 31));
      rd = $urandom;
      run_op(ro, rn, rd, ref_shift(ro, rn, rd), 0, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameters SHALL be NBITS, default 32, datapath word width; S_CONTROL, default 2, shifter control width; CNT_W, default 5, step-count width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  1  0 = SLL8 per step, 1 = SRA1 per step.
REQ-006 count  input  CNT_W  number of shifter passes (0..2^CNT_W-1).
REQ-007 data_in  input  NBITS  operand, captured with start.
REQ-008 abort  input  1  cancel an operation in progress.
REQ-009 c  output  NBITS  operand driven to the shifter.
REQ-010 s_control  output  S_CONTROL  shifter control: 2'b10 = SLL8, 2'b01 = SRA1, 2'b00 = pass-through.
REQ-011 c_bus  input  NBITS  shifter result, combinational return from c and s_control.
REQ-012 busy  output  1  high in SHIFT and DONE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 result  output  NBITS  final value, valid from done and held until the next accepted start.

Function
REQ-015 FSM SHALL have states IDLE, SHIFT and DONE, held in a registered state variable.
REQ-016 IDLE with start=1 SHALL capture acc<=data_in, rem<=count and op_q<=op.
REQ-017 From IDLE, the next state SHALL be SHIFT if count!=0, else DONE.
REQ-018 In SHIFT, each cycle SHALL update acc<=c_bus and rem<=rem-1.
REQ-019 SHIFT SHALL transition to DONE in the cycle where rem==1, so exactly count shifter passes occur.
REQ-020 c SHALL equal acc at all times.
REQ-021 s_control SHALL equal SLL8 or SRA1 per op_q in SHIFT, and 2'b00 in IDLE and DONE.
REQ-022 DONE SHALL assert done for exactly one cycle, then return unconditionally to IDLE.
REQ-023 result SHALL be driven from acc, so it reflects the final value from DONE onward.
REQ-024 Latency: with start accepted at the clock edge ending cycle 0, done SHALL be high in cycle count+1 (count=0 gives cycle 1).
REQ-025 start while busy SHALL be ignored, with no effect on state, acc, rem or op_q.
REQ-026 start in the DONE cycle SHALL be ignored; it is accepted only in IDLE.
REQ-027 abort=1 in SHIFT SHALL return the FSM to IDLE next cycle, with no done pulse and acc holding its partial value.
REQ-028 abort in IDLE or DONE SHALL have no effect; if start and abort are both high in IDLE, start wins.
REQ-029 No early termination: SLL8 with count>=4 SHALL yield 0 after the full count cycles.
REQ-030 SRA1 SHALL sign-fill; after >=NBITS-1 passes the result is all sign bits.
REQ-031 rem SHALL never wrap: decrement occurs only in SHIFT, where rem>=1.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force state=IDLE, acc=0, rem=0 and op_q=0.
REQ-033 In consequence of REQ-032, reset SHALL give busy=0, done=0, result=0, c=0 and s_control=2'b00.
REQ-034 Reset SHALL override start and abort, and any operation in flight SHALL be discarded without a done pulse.

Structure
REQ-035 NBITS, S_CONTROL, the SLL8/SRA1 control encodings and the FSM state enum SHALL live in the shared definitions package.
REQ-036 The shifter SHALL be instantiated outside this block; shift_sequencer connects only through c, s_control and c_bus.
REQ-037 A bench wrapper shift_unit SHALL instantiate shift_sequencer together with the existing shifter.

Verification
REQ-038 op=1, count=3, data_in=0x8000_0010 -> done in cycle 4, result=0xF000_0002.
REQ-039 op=0, count=2, data_in=0x0000_12AB -> done in cycle 3, result=0x12AB_0000.
REQ-040 count=0, data_in=0xDEAD_BEEF -> done in cycle 1, result=0xDEAD_BEEF, s_control never nonzero.
REQ-041 op=0, count=5, data_in=0x1234_5678 -> done in cycle 6, result=0; a second start in cycle 2 is ignored.
REQ-042 op=1, count=4, abort in cycle 2 -> IDLE in cycle 3, no done; a new start is then accepted normally.
REQ-043 rst_n=0 during SHIFT -> next cycle busy=0, done=0, result=0, s_control=2'b00.
